// File: rtl/uart_fact_pkg.sv
// Shared constants for the UART factorial calculator: controller state encoding,
// operand limit, response framing and the result byte selector.
package uart_fact_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  // 13! no longer fits in 32 bits, so 12 is the largest operand we accept.
  localparam logic [7:0] MAX_N         = 8'd12;
  localparam int         RESP_BYTES    = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(RESP_BYTES - 1);
  localparam logic [7:0] ERR_BYTE      = 8'hEE;

  // Byte 0 is the most significant byte, matching the on-wire order.
  function automatic logic [7:0] result_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_fact_ctrl_fact_engine.sv
// Iterative factorial unit: one 32x8 multiply per cycle, counting the operand down to 1.
module fact_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  n,
  output logic        done,
  output logic [31:0] result
);

  logic        running_q, running_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;

  // done is raised while the counter sits at 0 or 1, so n = 0 and n = 1 finish one cycle after start.
  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    done      = running_q && (cnt_q <= 8'd1);
    if (start) begin
      running_d = 1'b1;
      cnt_d     = n;
      acc_d     = 32'd1;
    end else if (running_q) begin
      if (cnt_q <= 8'd1) begin
        running_d = 1'b0;
      end else begin
        acc_d = acc_q * {24'd0, cnt_q};
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running_q <= 1'b0;
      cnt_q     <= 8'd0;
      acc_q     <= 32'd0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
    end
  end

  assign result = acc_q;

endmodule

// File: rtl/uart_fact_ctrl.sv
// Sequencer between uart_rx, the factorial engine and uart_tx: takes one operand byte,
// returns n! as four bytes MSB first, or a single error byte for operands above MAX_N.
module uart_fact_ctrl
  import uart_fact_pkg::*;
#(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_dout,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  output logic [31:0]     factorial_result,
  output logic            result_valid,
  output logic            busy,
  output logic            overflow_err,
  output logic            overrun_err
);

  logic [2:0]      state_q, state_d;
  logic [7:0]      n_q, n_d;
  logic [1:0]      idx_q, idx_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic [31:0]     result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            ovr_q, ovr_d;
  logic            valid_q;
  logic            eng_start;
  logic            eng_done;
  logic [31:0]     eng_result;

  fact_engine u_engine (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .n      (n_q),
    .done   (eng_done),
    .result (eng_result)
  );

  // tx_din is loaded on every transition into SEND so it is already valid alongside tx_start.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    tx_din_d  = tx_din_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    ovr_d     = ovr_q;
    eng_start = 1'b0;
    if (rx_done_tick && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (rx_done_tick) begin
          n_d     = 8'(rx_dout);
          ovf_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (n_q > MAX_N) begin
          ovf_d    = 1'b1;
          tx_din_d = DBIT'(ERR_BYTE);
          state_d  = ST_SEND;
        end else begin
          eng_start = 1'b1;
          state_d   = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (eng_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = eng_result;
        idx_d    = 2'd0;
        tx_din_d = DBIT'(result_byte(eng_result, 2'd0));
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // An overflow response is a single byte, so the error flag doubles as the length.
        if (tx_done_tick) begin
          if (ovf_q || (idx_q == LAST_BYTE_IDX)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + 2'd1;
            tx_din_d = DBIT'(result_byte(result_q, idx_q + 2'd1));
            state_d  = ST_SEND;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      n_q      <= 8'd0;
      idx_q    <= 2'd0;
      tx_din_q <= '0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      tx_din_q <= tx_din_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
      valid_q  <= (state_q == ST_DONE);
    end
  end

  assign tx_start         = (state_q == ST_SEND);
  assign busy             = (state_q != ST_IDLE);
  assign tx_din           = tx_din_q;
  assign factorial_result = result_q;
  assign result_valid     = valid_q;
  assign overflow_err     = ovf_q;
  assign overrun_err      = ovr_q;

endmodule
